traffic_light_sequencer: RTL and testbench

Timed phase sequencer that drives the 2-bit `state` input of the traffic light decoder stage. It cycles RED -> GREEN -> YELLOW -> RED with parameterised per-phase durations. It supports a latched pedestrian request that shortens GREEN (never below a minimum green time) and an emergency input that forces the light to RED via YELLOW. Its `state` output connects directly to the decoder's `state` input.

---
 rtl/traffic_light_sequencer.sv | 121 ++++++++++++
 tb/tb_traffic_light_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_sequencer.sv
// Timed RED -> GREEN -> YELLOW phase sequencer with a latched pedestrian
// request that shortens GREEN and an emergency input that parks the light on RED.
module traffic_light_sequencer #(
    parameter int unsigned RED_CYCLES    = 10,
    parameter int unsigned GREEN_CYCLES  = 8,
    parameter int unsigned YELLOW_CYCLES = 3,
    parameter int unsigned MIN_GREEN     = 3,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             ped_req,
    input  logic             emergency,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] remaining,
    output logic             phase_start,
    output logic             ped_pending
);

    typedef enum logic [1:0] {
        ST_RED    = 2'b00,
        ST_YELLOW = 2'b01,
        ST_GREEN  = 2'b10,
        ST_BAD    = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] RED_LOAD    = CNT_W'(RED_CYCLES - 1);
    localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_CYCLES - 1);
    // GREEN may be cut once the count has fallen to this value, which
    // guarantees at least MIN_GREEN cycles of GREEN before YELLOW.
    localparam logic [CNT_W-1:0] PED_CUT     = CNT_W'(GREEN_CYCLES - MIN_GREEN);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             ps_q, ps_d;
    logic             ped_q, ped_d;

    // NOTE: every signal gets a default before the case so no path can leave
    // it unassigned; that is what keeps this block from inferring latches.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        ps_d    = 1'b0;
        ped_d   = ped_q | ped_req;

        unique case (state_q)
            ST_RED: begin
                if (emergency) begin
                    rem_d = RED_LOAD;
                end else if (enable) begin
                    if (rem_q == '0) begin
                        state_d = ST_GREEN;
                        rem_d   = GREEN_LOAD;
                        ps_d    = 1'b1;
                    end else begin
                        rem_d = rem_q - CNT_W'(1);
                    end
                end
            end

            ST_GREEN: begin
                if (emergency) begin
                    // Forced exit does not serve the pedestrian; the request stays latched.
                    state_d = ST_YELLOW;
                    rem_d   = YELLOW_LOAD;
                    ps_d    = 1'b1;
                end else if (enable) begin
                    if (rem_q == '0 || (ped_q && rem_q <= PED_CUT)) begin
                        state_d = ST_YELLOW;
                        rem_d   = YELLOW_LOAD;
                        ps_d    = 1'b1;
                        ped_d   = ped_req;
                    end else begin
                        rem_d = rem_q - CNT_W'(1);
                    end
                end
            end

            ST_YELLOW: begin
                if (emergency || enable) begin
                    if (rem_q == '0) begin
                        state_d = ST_RED;
                        rem_d   = RED_LOAD;
                        ps_d    = 1'b1;
                    end else begin
                        rem_d = rem_q - CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_RED;
                rem_d   = RED_LOAD;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RED;
            rem_q   <= RED_LOAD;
            ps_q    <= 1'b0;
            ped_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            ps_q    <= ps_d;
            ped_q   <= ped_d;
        end
    end

    assign state       = state_q;
    assign remaining   = rem_q;
    assign phase_start = ps_q;
    assign ped_pending = ped_q;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Directed bench for traffic_light_sequencer with default parameters; cycle 0
// is the first cycle after rst deasserts and outputs are sampled on the falling edge.
module tb_traffic_light_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       ped_req;
    logic       emergency;
    logic [1:0] state;
    logic [7:0] remaining;
    logic       phase_start;
    logic       ped_pending;

    int n_total     = 0;
    int n_pass      = 0;
    int n_bad_state = 0;

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;

    traffic_light_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .ped_req     (ped_req),
        .emergency   (emergency),
        .state       (state),
        .remaining   (remaining),
        .phase_start (phase_start),
        .ped_pending (ped_pending)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (state === 2'b11) n_bad_state++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag, input logic [1:0] st, input logic [7:0] rem,
                             input logic ps, input logic pp);
        check({tag, " state"},       32'(state),       32'(st));
        check({tag, " remaining"},   32'(remaining),   32'(rem));
        check({tag, " phase_start"}, 32'(phase_start), 32'(ps));
        check({tag, " ped_pending"}, 32'(ped_pending), 32'(pp));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Leaves the bench at the sampling point of cycle 0 with rst low.
    task automatic do_reset();
        rst       = 1'b1;
        enable    = 1'b1;
        ped_req   = 1'b0;
        emergency = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; ped_req = 1'b0; emergency = 1'b0;
        @(negedge clk);

        // 1. Free run over one full 21-cycle period
        do_reset();
        check_all("reset", RED, 8'd9, 1'b0, 1'b0);
        for (int c = 0; c <= 21; c++) begin
            if (c < 10)
                check_all($sformatf("run c%0d", c), RED, 8'(9 - c), 1'b0, 1'b0);
            else if (c < 18)
                check_all($sformatf("run c%0d", c), GREEN, 8'(17 - c), c == 10, 1'b0);
            else if (c < 21)
                check_all($sformatf("run c%0d", c), YELLOW, 8'(20 - c), c == 18, 1'b0);
            else
                check_all($sformatf("run c%0d", c), RED, 8'd9, 1'b1, 1'b0);
            tick();
        end

        // 2. Freeze: enable low during cycles 4..8
        do_reset();
        for (int c = 0; c <= 15; c++) begin
            if (c >= 4 && c <= 9)
                check_all($sformatf("frz c%0d", c), RED, 8'd5, 1'b0, 1'b0);
            if (c == 14)
                check_all("frz c14", RED, 8'd0, 1'b0, 1'b0);
            if (c == 15)
                check_all("frz c15", GREEN, 8'd7, 1'b1, 1'b0);
            enable = !(c >= 4 && c <= 8);
            tick();
        end
        enable = 1'b1;

        // 3a. Pedestrian pulse in RED cuts GREEN to 3 cycles
        do_reset();
        for (int c = 0; c <= 14; c++) begin
            check($sformatf("ped c%0d pending", c), 32'(ped_pending), 32'(c >= 3 && c < 13));
            if (c >= 10 && c <= 12)
                check_all($sformatf("ped c%0d", c), GREEN, 8'(17 - c), c == 10, 1'b1);
            if (c == 13)
                check_all("ped c13", YELLOW, 8'd2, 1'b1, 1'b0);
            ped_req = (c == 2);
            tick();
        end
        ped_req = 1'b0;

        // 3b. Pedestrian request at GREEN index 5 gives 7 GREEN cycles
        do_reset();
        for (int c = 0; c <= 17; c++) begin
            if (c >= 10 && c <= 16)
                check($sformatf("ped5 c%0d state", c), 32'(state), 32'(GREEN));
            if (c == 16)
                check_all("ped5 c16", GREEN, 8'd1, 1'b0, 1'b1);
            if (c == 17)
                check_all("ped5 c17", YELLOW, 8'd2, 1'b1, 1'b0);
            ped_req = (c == 15);
            tick();
        end
        ped_req = 1'b0;

        // 4. Emergency at GREEN index 2 with enable low, then release
        do_reset();
        for (int c = 0; c < 12; c++) tick();
        check_all("emg c12", GREEN, 8'd5, 1'b0, 1'b0);
        emergency = 1'b1;
        enable    = 1'b0;
        tick();
        check_all("emg c13", YELLOW, 8'd2, 1'b1, 1'b0);
        tick();
        check_all("emg c14", YELLOW, 8'd1, 1'b0, 1'b0);
        tick();
        check_all("emg c15", YELLOW, 8'd0, 1'b0, 1'b0);
        tick();
        check_all("emg c16", RED, 8'd9, 1'b1, 1'b0);
        for (int c = 17; c <= 19; c++) begin
            tick();
            check_all($sformatf("emg hold c%0d", c), RED, 8'd9, 1'b0, 1'b0);
        end
        enable = 1'b1;
        tick();
        check_all("emg c20", RED, 8'd9, 1'b0, 1'b0);
        emergency = 1'b0;
        for (int c = 20; c < 29; c++) tick();
        check_all("emg c29", RED, 8'd0, 1'b0, 1'b0);
        tick();
        check_all("emg c30", GREEN, 8'd7, 1'b1, 1'b0);

        // 5. Reset mid-GREEN with a pending request
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            ped_req = (c == 2);
            tick();
        end
        check_all("rst c11", GREEN, 8'd6, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all("rst after", RED, 8'd9, 1'b0, 1'b0);

        // 6. Set/clear collision keeps the request for the next GREEN
        do_reset();
        for (int c = 0; c <= 29; c++) begin
            if (c == 13) check_all("col c13", YELLOW, 8'd2, 1'b1, 1'b1);
            if (c == 26) check_all("col c26", GREEN, 8'd7, 1'b1, 1'b1);
            if (c == 28) check_all("col c28", GREEN, 8'd5, 1'b0, 1'b1);
            if (c == 29) check_all("col c29", YELLOW, 8'd2, 1'b1, 1'b0);
            ped_req = (c == 2 || c == 12);
            tick();
        end
        ped_req = 1'b0;

        check("state never 11", 32'(n_bad_state), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
